imem_loader: RTL and testbench

- Writer side of the instruction-memory read path. Accepts a byte stream over a valid/ready handshake and packs it big-endian into 32-bit words.
- Writes each word into instruction memory at sequential word addresses, starting at 0.
- Holds the single-cycle core (cpu_hold) until the image is loaded, then releases it so the PC fetches from address 0.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_byte_packer.sv | 66 ++++++
 rtl/imem_loader.sv | 191 +++++++++++++++++++
 tb/tb_imem_loader.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM states and byte-lane indexing.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        FULL,
        DONE
    } state_e;

    localparam int unsigned BYTES_PER_WORD = 4;

    typedef logic [1:0] lane_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte packer: lane 0 lands in bits [31:24]; a short final word is padded from FILL_WORD.
// Optional port aligned_o exists only when IMEM_LOADER_CKSUM_EN is defined.
module byte_packer
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] FILL_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  data_i,
    input  logic        last_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
`ifdef IMEM_LOADER_CKSUM_EN
    ,
    output logic        aligned_o
`endif
);

    lane_t       idx_q, idx_d;
    logic [31:0] pack_q, pack_d;
    logic        at_last_lane;

    assign at_last_lane = (idx_q == lane_t'(BYTES_PER_WORD - 1));

    always_comb begin
        pack_d       = pack_q;
        idx_d        = idx_q;
        word_ready_o = 1'b0;
        if (clear_i) begin
            idx_d = '0;
        end else if (accept_i) begin
            // Lanes after the current one are only overwritten when the image ends here.
            for (int unsigned lane = 0; lane < BYTES_PER_WORD; lane++) begin
                if (lane_t'(lane) == idx_q) begin
                    pack_d[(BYTES_PER_WORD - 1 - lane) * 8 +: 8] = data_i;
                end else if (last_i && (lane_t'(lane) > idx_q)) begin
                    pack_d[(BYTES_PER_WORD - 1 - lane) * 8 +: 8] =
                        FILL_WORD[(BYTES_PER_WORD - 1 - lane) * 8 +: 8];
                end
            end
            word_ready_o = at_last_lane || last_i;
            idx_d        = word_ready_o ? '0 : idx_q + 2'd1;
        end
    end

    // Expose the word including the byte accepted this cycle so the caller can latch it.
    assign word_o = pack_d;

`ifdef IMEM_LOADER_CKSUM_EN
    assign aligned_o = accept_i && at_last_lane;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q  <= '0;
            pack_q <= '0;
        end else begin
            idx_q  <= idx_d;
            pack_q <= pack_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte-stream image into instruction memory, holding the core until the load completes.
// Define IMEM_LOADER_CKSUM_EN to treat the final aligned word as an XOR checksum (adds cksum_err).
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [31:0] FILL_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count
`ifdef IMEM_LOADER_CKSUM_EN
    ,
    output logic              cksum_err
`endif
);

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d, count_inc;
    logic              ovf_q, ovf_d;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [31:0]       acc_q, acc_d;
    logic              err_q, err_d;
    logic              aligned;
`else
    logic              last_q, last_d;
`endif

    logic        accept;
    logic        start_load;
    logic        word_ready;
    logic [31:0] word;

    assign in_ready   = (state_q == COLLECT);
    assign accept     = in_valid && in_ready;
    assign start_load = start && ((state_q == IDLE) || (state_q == FULL) || (state_q == DONE));
    assign count_inc  = count_q + 1'b1;

    byte_packer #(
        .FILL_WORD(FILL_WORD)
    ) u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (start_load),
        .accept_i    (accept),
        .data_i      (in_data),
        .last_i      (in_last),
        .word_o      (word),
        .word_ready_o(word_ready)
`ifdef IMEM_LOADER_CKSUM_EN
        ,
        .aligned_o   (aligned)
`endif
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
`ifdef IMEM_LOADER_CKSUM_EN
        acc_d     = acc_q;
        err_d     = err_q;
`else
        last_d    = last_q;
`endif
        imem_we   = 1'b0;
        load_done = 1'b0;
        cpu_hold  = 1'b1;

        case (state_q)
            IDLE: ;
            COLLECT: begin
                if (word_ready) begin
`ifdef IMEM_LOADER_CKSUM_EN
                    // The word closing the image is the checksum: compared, never written.
                    if (in_last) begin
                        state_d = DONE;
                        err_d   = !aligned || (word != acc_q);
                    end else begin
                        wdata_d = word;
                        state_d = WRITE;
                    end
`else
                    wdata_d = word;
                    last_d  = in_last;
                    state_d = WRITE;
`endif
                end
            end
            WRITE: begin
                imem_we = 1'b1;
                count_d = count_inc;
                // The address saturates on the final slot instead of wrapping to 0.
                if (count_inc != CAPACITY) begin
                    addr_d = addr_q + 1'b1;
                end
`ifdef IMEM_LOADER_CKSUM_EN
                acc_d   = acc_q ^ wdata_q;
                state_d = (count_inc == CAPACITY) ? FULL : COLLECT;
`else
                if (last_q) begin
                    state_d = DONE;
                end else if (count_inc == CAPACITY) begin
                    state_d = FULL;
                end else begin
                    state_d = COLLECT;
                end
`endif
            end
            FULL: begin
                if (in_valid) begin
                    ovf_d = 1'b1;
                end
            end
            DONE: begin
                load_done = 1'b1;
`ifdef IMEM_LOADER_CKSUM_EN
                cpu_hold  = err_q;
`else
                cpu_hold  = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase

        if (start_load) begin
            state_d = COLLECT;
            count_d = '0;
            addr_d  = '0;
            ovf_d   = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            acc_d   = '0;
            err_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            acc_q   <= '0;
            err_q   <= 1'b0;
`else
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
`ifdef IMEM_LOADER_CKSUM_EN
            acc_q   <= acc_d;
            err_q   <= err_d;
`else
            last_q  <= last_d;
`endif
        end
    end

    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign overflow   = ovf_q;
    assign word_count = count_q;
`ifdef IMEM_LOADER_CKSUM_EN
    assign cksum_err  = err_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: default-size and 4-word instances, write scoreboard per instance.
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset;

    logic        d_start, d_in_valid, d_in_last;
    logic [7:0]  d_in_data;
    logic        d_in_ready, d_imem_we, d_cpu_hold, d_load_done, d_overflow;
    logic [7:0]  d_imem_addr;
    logic [31:0] d_imem_wdata;
    logic [8:0]  d_word_count;

    logic        s_start, s_in_valid, s_in_last;
    logic [7:0]  s_in_data;
    logic        s_in_ready, s_imem_we, s_cpu_hold, s_load_done, s_overflow;
    logic [1:0]  s_imem_addr;
    logic [31:0] s_imem_wdata;
    logic [2:0]  s_word_count;
`ifdef IMEM_LOADER_CKSUM_EN
    logic        d_cksum_err, s_cksum_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t d_exp[$];
    wr_t s_exp[$];
    wr_t d_e, s_e;

    imem_loader #(.ADDR_W(8), .FILL_WORD(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset), .start(d_start), .in_valid(d_in_valid),
        .in_data(d_in_data), .in_last(d_in_last), .in_ready(d_in_ready),
        .imem_we(d_imem_we), .imem_addr(d_imem_addr), .imem_wdata(d_imem_wdata),
        .cpu_hold(d_cpu_hold), .load_done(d_load_done), .overflow(d_overflow),
        .word_count(d_word_count)
`ifdef IMEM_LOADER_CKSUM_EN
        , .cksum_err(d_cksum_err)
`endif
    );

    imem_loader #(.ADDR_W(2), .FILL_WORD(32'h0000_0000)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .in_valid(s_in_valid),
        .in_data(s_in_data), .in_last(s_in_last), .in_ready(s_in_ready),
        .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
        .cpu_hold(s_cpu_hold), .load_done(s_load_done), .overflow(s_overflow),
        .word_count(s_word_count)
`ifdef IMEM_LOADER_CKSUM_EN
        , .cksum_err(s_cksum_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (d_imem_we !== 1'b0) begin
            if (d_exp.size() == 0) begin
                check("d_unexpected_we", 32'(d_imem_we), 32'd0);
            end else begin
                d_e = d_exp.pop_front();
                check("d_wr_addr", 32'(d_imem_addr), 32'(d_e.addr));
                check("d_wr_data", d_imem_wdata, d_e.data);
            end
        end
        if (s_imem_we !== 1'b0) begin
            if (s_exp.size() == 0) begin
                check("s_unexpected_we", 32'(s_imem_we), 32'd0);
            end else begin
                s_e = s_exp.pop_front();
                check("s_wr_addr", 32'(s_imem_addr), 32'(s_e.addr));
                check("s_wr_data", s_imem_wdata, s_e.data);
            end
        end
    end

    task automatic push_d(input logic [7:0] a, input logic [31:0] w);
        wr_t e;
        e.addr = a;
        e.data = w;
        d_exp.push_back(e);
    endtask

    task automatic push_s(input logic [7:0] a, input logic [31:0] w);
        wr_t e;
        e.addr = a;
        e.data = w;
        s_exp.push_back(e);
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b, input logic last);
        bit ok;
        if (sel) begin
            s_in_valid = 1'b1; s_in_data = b; s_in_last = last;
        end else begin
            d_in_valid = 1'b1; d_in_data = b; d_in_last = last;
        end
        ok = 1'b0;
        for (int cyc = 0; cyc < 40 && !ok; cyc++) begin
            @(negedge clk);
            ok = sel ? s_in_ready : d_in_ready;
        end
        if (!ok) check("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        if (sel) begin
            s_in_valid = 1'b0; s_in_last = 1'b0;
        end else begin
            d_in_valid = 1'b0; d_in_last = 1'b0;
        end
    endtask

    task automatic send_word(input bit sel, input logic [31:0] w, input logic last);
        logic [31:0] v;
        v = w;
        send_byte(sel, v[31:24], 1'b0);
        send_byte(sel, v[23:16], 1'b0);
        send_byte(sel, v[15:8],  1'b0);
        send_byte(sel, v[7:0],   last);
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) s_start = 1'b1; else d_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        d_start = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int cyc = 0; cyc < 40 && !ok; cyc++) begin
            @(negedge clk);
            ok = d_load_done;
        end
        if (!ok) check("done_timeout", 32'(ok), 32'd1);
    endtask

    task automatic check_reset_state();
        check("rst_in_ready",   32'(d_in_ready),   32'd0);
        check("rst_imem_we",    32'(d_imem_we),    32'd0);
        check("rst_imem_addr",  32'(d_imem_addr),  32'd0);
        check("rst_imem_wdata", d_imem_wdata,      32'd0);
        check("rst_cpu_hold",   32'(d_cpu_hold),   32'd1);
        check("rst_load_done",  32'(d_load_done),  32'd0);
        check("rst_overflow",   32'(d_overflow),   32'd0);
        check("rst_word_count", 32'(d_word_count), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        d_start = 1'b0; d_in_valid = 1'b0; d_in_last = 1'b0; d_in_data = '0;
        s_start = 1'b0; s_in_valid = 1'b0; s_in_last = 1'b0; s_in_data = '0;
        #12;
        check_reset_state();
        check("s_rst_word_count", 32'(s_word_count), 32'd0);
        check("s_rst_cpu_hold",   32'(s_cpu_hold),   32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

`ifndef IMEM_LOADER_CKSUM_EN
        // Two-word image, with write latency checked after the 4th byte.
        pulse_start(0);
        push_d(8'd0, 32'h2008_0005);
        push_d(8'd1, 32'h2009_0007);
        send_byte(0, 8'h20, 1'b0);
        send_byte(0, 8'h08, 1'b0);
        send_byte(0, 8'h00, 1'b0);
        send_byte(0, 8'h05, 1'b0);
        @(negedge clk);
        check("lat_we",    32'(d_imem_we),  32'd1);
        check("lat_ready", 32'(d_in_ready), 32'd0);
        send_byte(0, 8'h20, 1'b0);
        send_byte(0, 8'h09, 1'b0);
        send_byte(0, 8'h00, 1'b0);
        send_byte(0, 8'h07, 1'b1);
        wait_done();
        check("t1_word_count", 32'(d_word_count), 32'd2);
        check("t1_load_done",  32'(d_load_done),  32'd1);
        check("t1_cpu_hold",   32'(d_cpu_hold),   32'd0);
        check("t1_in_ready",   32'(d_in_ready),   32'd0);
        check("t1_q_empty",    32'(d_exp.size()), 32'd0);

        // Same image with 3-cycle stalls and a start pulse mid-COLLECT.
        pulse_start(0);
        check("t2_hold_restart", 32'(d_cpu_hold), 32'd1);
        push_d(8'd0, 32'h2008_0005);
        push_d(8'd1, 32'h2009_0007);
        send_byte(0, 8'h20, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        send_byte(0, 8'h08, 1'b0);
        pulse_start(0);
        @(negedge clk);
        check("t2_start_ignored", 32'(d_in_ready), 32'd1);
        @(posedge clk);
        #1;
        send_byte(0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        send_byte(0, 8'h05, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        send_byte(0, 8'h20, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        send_byte(0, 8'h09, 1'b0);
        send_byte(0, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        send_byte(0, 8'h07, 1'b1);
        wait_done();
        check("t2_word_count", 32'(d_word_count), 32'd2);
        check("t2_q_empty",    32'(d_exp.size()), 32'd0);

        // Partial final word padded from FILL_WORD.
        pulse_start(0);
        push_d(8'd0, 32'hAABB_CCDD);
        push_d(8'd1, 32'h1122_0000);
        send_word(0, 32'hAABB_CCDD, 1'b0);
        send_byte(0, 8'h11, 1'b0);
        send_byte(0, 8'h22, 1'b1);
        wait_done();
        check("t3_word_count", 32'(d_word_count), 32'd2);
        check("t3_q_empty",    32'(d_exp.size()), 32'd0);

        // in_last on the very first byte of a word.
        pulse_start(0);
        push_d(8'd0, 32'h7F00_0000);
        send_byte(0, 8'h7F, 1'b1);
        wait_done();
        check("t3b_word_count", 32'(d_word_count), 32'd1);
        check("t3b_cpu_hold",   32'(d_cpu_hold),   32'd0);
        check("t3b_q_empty",    32'(d_exp.size()), 32'd0);
`else
        // Checksum matches: two data words, XOR = 3.
        pulse_start(0);
        push_d(8'd0, 32'h0000_0001);
        push_d(8'd1, 32'h0000_0002);
        send_word(0, 32'h0000_0001, 1'b0);
        send_word(0, 32'h0000_0002, 1'b0);
        send_word(0, 32'h0000_0003, 1'b1);
        wait_done();
        check("ck_ok_err",        32'(d_cksum_err),  32'd0);
        check("ck_ok_word_count", 32'(d_word_count), 32'd2);
        check("ck_ok_cpu_hold",   32'(d_cpu_hold),   32'd0);
        check("ck_ok_q_empty",    32'(d_exp.size()), 32'd0);

        // Checksum mismatch keeps the core held.
        pulse_start(0);
        push_d(8'd0, 32'h0000_0001);
        push_d(8'd1, 32'h0000_0002);
        send_word(0, 32'h0000_0001, 1'b0);
        send_word(0, 32'h0000_0002, 1'b0);
        send_word(0, 32'h0000_0004, 1'b1);
        wait_done();
        check("ck_bad_err",       32'(d_cksum_err),  32'd1);
        check("ck_bad_cpu_hold",  32'(d_cpu_hold),   32'd1);
        check("ck_bad_load_done", 32'(d_load_done),  32'd1);
        check("ck_bad_q_empty",   32'(d_exp.size()), 32'd0);
`endif

        // Capacity: 4-word instance fed 16 bytes, then extra bytes in FULL.
        pulse_start(1);
        for (int k = 0; k < 4; k++) begin
            push_s(8'(k), {8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)});
        end
        for (int i = 0; i < 16; i++) begin
            send_byte(1, 8'(i + 1), 1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        check("full_in_ready",     32'(s_in_ready),   32'd0);
        check("full_ovf_before",   32'(s_overflow),   32'd0);
        s_in_valid = 1'b1;
        s_in_data  = 8'hEE;
        repeat (4) @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        @(negedge clk);
        check("full_overflow",     32'(s_overflow),     32'd1);
        check("full_word_count",   32'(s_word_count),   32'd4);
        check("full_addr_no_wrap", 32'(s_imem_addr),    32'd3);
        check("full_load_done",    32'(s_load_done),    32'd0);
        check("full_cpu_hold",     32'(s_cpu_hold),     32'd1);
        check("full_q_empty",      32'(s_exp.size()),   32'd0);

        // Reset during the 3rd byte of word 1 aborts at once; no later writes.
        pulse_start(0);
        push_d(8'd0, 32'h0102_0304);
        send_word(0, 32'h0102_0304, 1'b0);
        send_byte(0, 8'h05, 1'b0);
        send_byte(0, 8'h06, 1'b0);
        d_in_valid = 1'b1;
        d_in_data  = 8'h07;
        #2;
        reset = 1'b1;
        #1;
        check_reset_state();
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        d_in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(d_in_ready),   32'd0);
        check("post_rst_count", 32'(d_word_count), 32'd0);
        check("post_rst_q",     32'(d_exp.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
